uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM,
// one-cycle data-valid / framing-error pulses, and a held byte register.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_serial_i,
  output logic       rx_dv_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_frame_err_o,
  output logic       rx_active_o
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    CLEANUP    = 3'd4,
    BREAK_WAIT = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
  logic        rx_meta;
  logic        rx_s;
  logic        rst_meta;
  logic        rst_sync;

  // Reset asserts immediately and releases only after two clean clock edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_sync) begin
    if (rst_sync) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_sync) begin
    if (rst_sync) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      bit_idx        <= 3'd0;
      shift_q        <= 8'h00;
      rx_byte_o      <= 8'h00;
      rx_dv_o        <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_active_o    <= 1'b0;
    end else begin
      rx_dv_o        <= 1'b0;
      rx_frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 16'd0;
          bit_idx <= 3'd0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Re-check the line at the middle of the start bit to reject glitches.
          if (cnt == CNT_HALF) begin
            cnt <= 16'd0;
            if (!rx_s) begin
              rx_active_o <= 1'b1;
              state       <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt              <= 16'd0;
            shift_q[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt         <= 16'd0;
            rx_active_o <= 1'b0;
            if (rx_s) begin
              rx_byte_o <= shift_q;
              rx_dv_o   <= 1'b1;
              state     <= CLEANUP;
            end else begin
              rx_frame_err_o <= 1'b1;
              state          <= BREAK_WAIT;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CLEANUP: begin
          cnt   <= 16'd0;
          state <= IDLE;
        end
        BREAK_WAIT: begin
          // A held-low (break) line must go idle before another frame is accepted.
          cnt <= 16'd0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          cnt         <= 16'd0;
          bit_idx     <= 3'd0;
          rx_active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for back-to-back, glitch, break/framing-error and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_serial_i;
  logic       rx_dv_o;
  logic [7:0] rx_byte_o;
  logic       rx_frame_err_o;
  logic       rx_active_o;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .rx_serial_i    (rx_serial_i),
    .rx_dv_o        (rx_dv_o),
    .rx_byte_o      (rx_byte_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_active_o    (rx_active_o)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         dv_cnt = 0;
  int         err_cnt = 0;
  int         dv_cyc = 0;
  int         start_cyc = 0;
  bit         active_seen = 1'b0;
  logic [7:0] byte_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         period;
    int         exp_dv;
    int         exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts outputs and records received bytes.
  always @(negedge clk) begin
    if (rx_active_o) active_seen = 1'b1;
    if (rx_dv_o || rx_frame_err_o)
      check("dv_err_exclusive", {31'd0, rx_dv_o & rx_frame_err_o}, 32'd0);
    if (rx_dv_o) begin
      dv_cnt++;
      dv_cyc = cyc;
      byte_q.push_back(rx_byte_o);
    end
    if (rx_frame_err_o) err_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int period);
    start_cyc   = cyc;
    rx_serial_i = 1'b0;
    wait_cyc(period);
    for (int i = 0; i < 8; i++) begin
      rx_serial_i = d[i];
      wait_cyc(period);
    end
    rx_serial_i = stop;
    wait_cyc(period);
  endtask

  initial begin
    int dv0, err0, lat;

    vecs[0] = '{8'h37, 1'b1, 217, 1, 0, 8'h37};
    vecs[1] = '{8'h00, 1'b1, 217, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 217, 1, 0, 8'hFF};
    vecs[3] = '{8'hA5, 1'b1, 217, 1, 0, 8'hA5};
    vecs[4] = '{8'h96, 1'b1, 211, 1, 0, 8'h96};
    vecs[5] = '{8'h96, 1'b1, 223, 1, 0, 8'h96};
    vecs[6] = '{8'h01, 1'b1, 217, 1, 0, 8'h01};
    vecs[7] = '{8'h80, 1'b1, 217, 1, 0, 8'h80};

    rst_i       = 1'b1;
    rx_serial_i = 1'b1;
    wait_cyc(5);
    check("reset_dv", {31'd0, rx_dv_o}, 32'd0);
    check("reset_err", {31'd0, rx_frame_err_o}, 32'd0);
    check("reset_active", {31'd0, rx_active_o}, 32'd0);
    check("reset_byte", {24'd0, rx_byte_o}, 32'h00);
    rst_i = 1'b0;
    wait_cyc(10);

    // Framing error, long break, then a good frame.
    dv0 = dv_cnt; err0 = err_cnt;
    send_frame(8'h5A, 1'b0, CPB);
    wait_cyc(3000);
    rx_serial_i = 1'b1;
    wait_cyc(20);
    check("ferr_err_pulses", err_cnt - err0, 1);
    check("ferr_no_dv", dv_cnt - dv0, 0);
    check("ferr_byte_held", {24'd0, rx_byte_o}, 32'h00);
    check("ferr_inactive", {31'd0, rx_active_o}, 32'd0);
    send_frame(8'h11, 1'b1, CPB);
    wait_cyc(20);
    check("after_break_dv", dv_cnt - dv0, 1);
    check("after_break_byte", {24'd0, rx_byte_o}, 32'h11);
    check("after_break_err", err_cnt - err0, 1);

    // Start-bit glitch: 50 low cycles then high.
    dv0 = dv_cnt; err0 = err_cnt; active_seen = 1'b0;
    rx_serial_i = 1'b0;
    wait_cyc(50);
    rx_serial_i = 1'b1;
    wait_cyc(400);
    check("glitch_no_dv", dv_cnt - dv0, 0);
    check("glitch_no_err", err_cnt - err0, 0);
    check("glitch_no_active", {31'd0, active_seen}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      dv0 = dv_cnt; err0 = err_cnt;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].period);
      rx_serial_i = 1'b1;
      wait_cyc(20);
      check($sformatf("vec%0d_dv", v), dv_cnt - dv0, vecs[v].exp_dv);
      check($sformatf("vec%0d_err", v), err_cnt - err0, vecs[v].exp_err);
      check($sformatf("vec%0d_byte", v), {24'd0, rx_byte_o}, {24'd0, vecs[v].exp_byte});
      if (vecs[v].period == CPB) begin
        lat = dv_cyc - start_cyc;
        check($sformatf("vec%0d_latency_ok", v), {31'd0, (lat >= 2062 && lat <= 2066)}, 32'd1);
      end
    end

    // Back-to-back frames with no idle gap.
    byte_q.delete();
    err0 = err_cnt;
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    send_frame(8'hA5, 1'b1, CPB);
    wait_cyc(20);
    check("b2b_count", byte_q.size(), 3);
    if (byte_q.size() == 3) begin
      check("b2b_byte0", {24'd0, byte_q[0]}, 32'h00);
      check("b2b_byte1", {24'd0, byte_q[1]}, 32'hFF);
      check("b2b_byte2", {24'd0, byte_q[2]}, 32'hA5);
    end
    check("b2b_no_err", err_cnt - err0, 0);

    // Reset asserted during data bit 4 of 0xC3.
    dv0 = dv_cnt; err0 = err_cnt;
    rx_serial_i = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_serial_i = 1'(8'hC3 >> i);
      wait_cyc(CPB);
    end
    rx_serial_i = 1'b0;
    wait_cyc(100);
    check("midframe_active", {31'd0, rx_active_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("async_rst_active", {31'd0, rx_active_o}, 32'd0);
    check("async_rst_byte", {24'd0, rx_byte_o}, 32'h00);
    rx_serial_i = 1'b1;
    wait_cyc(10);
    rst_i = 1'b0;
    wait_cyc(3 * CPB);
    check("rst_no_dv", dv_cnt - dv0, 0);
    check("rst_no_err", err_cnt - err0, 0);
    send_frame(8'h3C, 1'b1, CPB);
    wait_cyc(20);
    check("post_rst_dv", dv_cnt - dv0, 1);
    check("post_rst_byte", {24'd0, rx_byte_o}, 32'h3C);
    check("post_rst_err", err_cnt - err0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
